// File: rtl/mul_share_scheduler.sv
// Shares one shift-and-add multiplier between two valid/ready requesters (round-robin grant).
// Optional build macro MUL_EARLY_TERM_EN ends the add/shift sequence once the multiplier is zero.
module mul_share_scheduler #(
  parameter int W = 8
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           req0_valid,
  input  logic [W-1:0]   req0_a,
  input  logic [W-1:0]   req0_b,
  output logic           req0_ready,
  input  logic           req1_valid,
  input  logic [W-1:0]   req1_a,
  input  logic [W-1:0]   req1_b,
  output logic           req1_ready,
  output logic           res_valid,
  output logic [2*W-1:0] res_data,
  output logic           res_id,
  input  logic           res_ready,
  output logic           busy,
  output logic [1:0]     o_state
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [W-1:0]   r_a;
  logic [2*W-1:0] r_bsh;
  logic [2*W-1:0] r_acc;
  logic [CW-1:0]  r_cnt;
  logic           r_id;
  logic           r_last;

  logic           w_grant0;
  logic           w_grant1;
  logic           w_accept;
  logic           w_exit;

  // On a tie the requester that did not win last time gets the core.
  assign w_grant0 = req0_valid & (~req1_valid | r_last);
  assign w_grant1 = req1_valid & (~req0_valid | ~r_last);
  assign w_accept = (r_state == IDLE) & (w_grant0 | w_grant1);

`ifdef MUL_EARLY_TERM_EN
  assign w_exit = (r_cnt == CW'(W)) | (r_a == '0);
`else
  assign w_exit = (r_cnt == CW'(W));
`endif

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // NOTE: default assignment first so no path leaves w_next unassigned (no latch).
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next = CALC;
      CALC:    if (w_exit) w_next = DONE;
      DONE:    if (res_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    res_valid  = 1'b0;
    res_data   = '0;
    res_id     = 1'b0;
    busy       = 1'b0;
    o_state    = r_state;
    unique case (r_state)
      IDLE: begin
        req0_ready = w_grant0;
        req1_ready = w_grant1;
      end
      CALC: busy = 1'b1;
      DONE: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        res_data  = r_acc;
        res_id    = r_id;
      end
      default: ;
    endcase
  end

  // Datapath: load on acceptance, one add/shift step per CALC cycle that does not exit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a    <= '0;
      r_bsh  <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_id   <= 1'b0;
      r_last <= 1'b1;
    end else if (w_accept) begin
      r_a    <= w_grant1 ? req1_a : req0_a;
      r_bsh  <= {{W{1'b0}}, (w_grant1 ? req1_b : req0_b)};
      r_acc  <= '0;
      r_cnt  <= '0;
      r_id   <= w_grant1;
      r_last <= w_grant1;
    end else if ((r_state == CALC) && !w_exit) begin
      if (r_a[0]) r_acc <= r_acc + r_bsh;
      r_a   <= r_a >> 1;
      r_bsh <= r_bsh << 1;
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: doc/mul_share_scheduler.md
# mul_share_scheduler

Sequences a shift-and-add multiplier core and shares it between two requesters. Each requester offers an unsigned W×W operand pair over a valid/ready handshake. A round-robin arbiter grants one job at a time. The block runs the add/shift sequence on its internal accumulator and returns a 2W-bit product tagged with the requester ID over a second valid/ready handshake. It sits between the shift-add datapath and its client logic, replacing ad-hoc start/done pulsing.

## Interface
Parameters:
- W, 8, operand width; product width is 2W.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has a job.
- req0_a  in  W  requester 0 multiplier (consumed LSB-first).
- req0_b  in  W  requester 0 multiplicand.
- req0_ready  out  1  requester 0 job accepted this cycle.
- req1_valid, req1_a, req1_b, req1_ready  as requester 0, for requester 1.
- res_valid  out  1  product available.
- res_data  out  2W  product a×b.
- res_id  out  1  requester that owns res_data.
- res_ready  in  1  consumer takes the result.
- busy  out  1  high in CALC or DONE.
- o_state  out  2  current state: IDLE=0, CALC=1, DONE=2.

## Operation
Internal registers:
- A: W-bit multiplier shift register.
- Bsh: 2W-bit multiplicand shift register.
- ACC: 2W-bit accumulator.
- cnt: step counter, counts 0..W.
- id: owner of the current job.
- last: 1-bit last-granted requester.

Arbitration (combinational, IDLE only):
- Only one requester valid: it is granted.
- Both valid: requester !last is granted.
- reqX_ready = (state==IDLE) & grantX. A ready is never high without its valid, and never high outside IDLE.

State machine:
- IDLE: on an accepted request (valid & ready):
  - A←a, Bsh←{0,b}, ACC←0, cnt←0, id←X, last←X.
  - Go to CALC.
- CALC: each cycle, check the exit condition first.
  - Exit: cnt==W, or (MUL_EARLY_TERM_EN defined and A==0). On exit go to DONE with no step.
  - Otherwise step: if A[0] then ACC←ACC+Bsh; A←A>>1; Bsh←Bsh<<1; cnt←cnt+1.
- DONE:
  - res_valid=1, res_data=ACC, res_id=id.
  - On res_ready go to IDLE.
- res_data and res_id are held stable while res_valid & !res_ready.

Arithmetic: unsigned only. The 2W-bit ACC cannot overflow, since the maximum product is (2^W−1)^2.

Reset (asynchronous, any state, including mid-CALC or DONE):
- State←IDLE; A, Bsh, ACC, cnt, id←0; last←1, so requester 0 wins the first tie.
- Outputs: res_valid=0, res_data=0, res_id=0, busy=0, o_state=0, readies=0.
- The in-flight job is discarded and no result is produced for it.

## Timing
- Acceptance at edge T, then:
  - Without the macro: steps occur at edges T+1..T+W, the DONE transition at edge T+W+1, and res_valid is high after edge T+W+1. This is a fixed latency of W+1 cycles.
  - With the macro: res_valid is high after edge T+p+1, where p = index of the highest set bit of a, plus 1 (p=0 for a=0).
- A result handshake at edge R returns the block to IDLE at R. The earliest next acceptance is at edge R+1, so there is a minimum of one IDLE cycle between jobs.
- Requests arriving during CALC or DONE wait. Requesters must hold valid and operands until ready.
- res_ready has no effect outside DONE.

## Configuration
- MUL_EARLY_TERM_EN:
  - Defined: CALC exits as soon as A==0. Latency depends on the data, with a minimum of 1 cycle.
  - Undefined: the exit comparator is compiled out and latency is always W+1.
- Products are identical in both builds.

## Test plan
- Reset: assert i_rst_n=0 mid-run, then release → all outputs 0, o_state=0; readies stay 0 with no valids.
- Single job: req0 a=3, b=12 accepted at edge T → res_valid after edge T+9 (W=8, macro undefined), res_data=36, res_id=0.
- Contention: req0 (a=14, b=14) and req1 (a=255, b=255) both valid after reset → req0 granted first, result 196, id 0. Then req1 is granted with one IDLE cycle in between, result 65025, id 1. Next tie goes to requester 0.
- Backpressure: hold res_ready=0 for 5 cycles in DONE with req1_valid=1 → res_valid, res_data and res_id stable, req1_ready=0 throughout. The job is accepted the cycle after res_ready rises.
- Reset mid-CALC: pull i_rst_n low 3 cycles after acceptance → immediate IDLE, no res_valid ever asserted for that job. A new job afterwards completes correctly.
- Early termination:
  - Macro defined: a=0, b=77 → res_data=0, latency 1. a=1, b=77 → res_data=77, latency 2.
  - Macro undefined: both cases have latency 9.
